// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the multi-cycle LEGv8 control sequencer.
// Holds state and class encodings, control word layout and opcode patterns.
package control_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EXEC0 = 2'b01,
        S_EXEC1 = 2'b10,
        S_EXEC2 = 2'b11
    } state_t;

    typedef enum logic [2:0] {
        C_IARITH,
        C_LDUR,
        C_STUR,
        C_B,
        C_BCOND,
        C_CBZ,
        C_ILLEGAL
    } class_t;

    localparam int CW_W = 29;

    // Field order from MSB to LSB is the datapath control word layout
    typedef struct packed {
        logic [1:0] psel;
        logic [4:0] da;
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] fsel;
        logic       regw;
        logic       ramw;
        logic [1:0] dsel;
        logic       bsel;
        logic       pcsel;
        logic       sl;
    } cw_t;

    localparam logic [1:0] PSEL_HOLD = 2'b00;
    localparam logic [1:0] PSEL_PC4  = 2'b01;
    localparam logic [1:0] PSEL_PCK  = 2'b10;
    localparam logic [1:0] DSEL_IDLE = 2'b00;
    localparam logic [1:0] DSEL_ALU  = 2'b01;
    localparam logic [1:0] DSEL_RAM  = 2'b10;
    localparam logic [4:0] FSEL_ADD  = 5'b01000;
    localparam logic [4:0] FSEL_SUB  = 5'b01001;

    localparam logic [6:0]  OP_IARITH = 7'b1000100;
    localparam logic [10:0] OP_LDUR   = 11'b11111000010;
    localparam logic [10:0] OP_STUR   = 11'b11111000000;
    localparam logic [5:0]  OP_B      = 6'b000101;
    localparam logic [7:0]  OP_BCOND  = 8'b01010100;
    localparam logic [7:0]  OP_CBZ    = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ   = 8'b10110101;

    function automatic class_t classify(logic [31:0] ir);
        class_t c;
        unique case (1'b1)
            ir[28:22] == OP_IARITH: c = C_IARITH;
            ir[31:21] == OP_LDUR:   c = C_LDUR;
            ir[31:21] == OP_STUR:   c = C_STUR;
            ir[31:26] == OP_B:      c = C_B;
            ir[31:24] == OP_BCOND:  c = C_BCOND;
            ir[31:24] == OP_CBZ:    c = C_CBZ;
            ir[31:24] == OP_CBNZ:   c = C_CBZ;
            default:                c = C_ILLEGAL;
        endcase
        return c;
    endfunction

    function automatic logic [63:0] sext9(logic [8:0] v);
        return {{55{v[8]}}, v};
    endfunction

    function automatic logic [63:0] sext19(logic [18:0] v);
        return {{45{v[18]}}, v};
    endfunction

    function automatic logic [63:0] sext26(logic [25:0] v);
        return {{38{v[25]}}, v};
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Fetch handshake plus datapath-facing signals of the control sequencer.
// master = fetch/datapath side, slave = sequencer side.
interface control_sequencer_if;
    import control_pkg::*;

    logic [31:0]     instruction;
    logic            instr_valid;
    logic            instr_ready;
    logic [3:0]      status;
    logic            alu_zero;
    logic            mem_ready;
    logic [CW_W-1:0] controlWord;
    logic [63:0]     K;
    logic [1:0]      state;
    logic            illegal;
    logic            mem_timeout;

    modport master (
        output instruction, instr_valid, status, alu_zero, mem_ready,
        input  instr_ready, controlWord, K, state, illegal, mem_timeout
    );

    modport slave (
        input  instruction, instr_valid, status, alu_zero, mem_ready,
        output instr_ready, controlWord, K, state, illegal, mem_timeout
    );

endinterface

// File: rtl/control_sequencer_branch_cond_eval.sv
// Evaluates a B.cond condition code against the {N,Z,C,V} flags.
// Pure combinational.
module branch_cond_eval
    import control_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_status,
    output logic       o_taken
);
    logic w_n, w_z, w_c, w_v;
    logic w_base;

    assign {w_n, w_z, w_c, w_v} = i_status;

    always_comb begin
        w_base = 1'b1;
        unique case (i_cond[3:1])
            3'd0: w_base = w_z;
            3'd1: w_base = w_c;
            3'd2: w_base = w_n;
            3'd3: w_base = w_v;
            3'd4: w_base = w_c & ~w_z;
            3'd5: w_base = (w_n == w_v);
            3'd6: w_base = ~w_z & (w_n == w_v);
            3'd7: w_base = 1'b1;
        endcase
    end

    // Odd codes negate their even partner, except 1111 which is also always
    assign o_taken = (i_cond[0] && i_cond[3:1] != 3'd7) ? ~w_base : w_base;

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle LEGv8 control unit: latches an instruction from fetch and
// sequences the datapath control word and K immediate one state per cycle.
module control_sequencer
    import control_pkg::*;
#(
    parameter logic [3:0] MAX_WAIT = 4'd15
) (
    input  logic               clock,
    input  logic               reset,
    control_sequencer_if.slave bus
);
    localparam logic [3:0] W_LAST = MAX_WAIT - 4'd1;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_ir;
    logic [3:0]  r_wait;
    logic        r_illegal;
    logic        r_timeout;

    class_t      w_class;
    logic        w_is_mem;
    logic        w_tmo;
    logic        w_set_ill;
    logic        w_cond_taken;
    logic        w_cb_taken;
    cw_t         w_cw;
    logic [63:0] w_k;

    assign w_class    = classify(r_ir);
    assign w_is_mem   = (w_class == C_LDUR) || (w_class == C_STUR);
    assign w_tmo      = (r_state == S_EXEC1) && w_is_mem
                        && !bus.mem_ready && (r_wait == W_LAST);
    assign w_set_ill  = (r_state == S_EXEC0) && (w_class == C_ILLEGAL);
    assign w_cb_taken = bus.alu_zero ^ r_ir[24];

    branch_cond_eval u_cond (
        .i_cond   (r_ir[3:0]),
        .i_status (bus.status),
        .o_taken  (w_cond_taken)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_ir      <= '0;
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && bus.instr_valid)
                r_ir <= bus.instruction;
            // Counts stalled EXEC1 cycles; any other state re-arms it
            if (r_state == S_EXEC1 && !bus.mem_ready)
                r_wait <= r_wait + 4'd1;
            else
                r_wait <= '0;
            r_illegal <= r_illegal | w_set_ill;
            r_timeout <= r_timeout | w_tmo;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        unique case (r_state)
            S_FETCH:
                w_next = bus.instr_valid ? S_EXEC0 : S_FETCH;
            S_EXEC0:
                if (w_is_mem || w_class == C_CBZ)
                    w_next = S_EXEC1;
            S_EXEC1:
                if (w_class == C_LDUR && bus.mem_ready)
                    w_next = S_EXEC2;
                else if (w_is_mem && !bus.mem_ready && !w_tmo)
                    w_next = S_EXEC1;
            S_EXEC2:
                w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_cw = '0;
        w_k  = '0;
        unique case (r_state)
            S_FETCH: ;
            S_EXEC0: begin
                unique case (w_class)
                    C_IARITH: begin
                        w_cw.psel = PSEL_PC4;
                        w_cw.da   = r_ir[4:0];
                        w_cw.sa   = r_ir[9:5];
                        w_cw.fsel = {FSEL_ADD[4:1], r_ir[30]};
                        w_cw.regw = 1'b1;
                        w_cw.dsel = DSEL_ALU;
                        w_cw.bsel = 1'b1;
                        w_cw.sl   = r_ir[29];
                        w_k       = {52'd0, r_ir[21:10]};
                    end
                    C_LDUR, C_STUR: begin
                        w_cw.sa   = r_ir[9:5];
                        w_cw.fsel = FSEL_ADD;
                        w_cw.bsel = 1'b1;
                        w_k       = sext9(r_ir[20:12]);
                    end
                    C_B: begin
                        w_cw.psel = PSEL_PCK;
                        w_k       = sext26(r_ir[25:0]);
                    end
                    C_BCOND: begin
                        w_cw.psel = w_cond_taken ? PSEL_PCK : PSEL_PC4;
                        w_k       = sext19(r_ir[23:5]);
                    end
                    C_CBZ: begin
                        w_cw.sa   = 5'd31;
                        w_cw.sb   = r_ir[4:0];
                        w_cw.fsel = FSEL_ADD;
                        w_k       = sext19(r_ir[23:5]);
                    end
                    default:
                        w_cw.psel = PSEL_PC4;
                endcase
            end
            S_EXEC1: begin
                unique case (w_class)
                    C_LDUR, C_STUR: begin
                        w_cw.sa   = r_ir[9:5];
                        w_cw.fsel = FSEL_ADD;
                        w_cw.bsel = 1'b1;
                        w_k       = sext9(r_ir[20:12]);
                        if (w_class == C_STUR) begin
                            w_cw.sb   = r_ir[4:0];
                            w_cw.ramw = bus.mem_ready;
                            if (bus.mem_ready || w_tmo)
                                w_cw.psel = PSEL_PC4;
                        end else begin
                            w_cw.dsel = DSEL_RAM;
                            if (w_tmo)
                                w_cw.psel = PSEL_PC4;
                        end
                    end
                    C_CBZ: begin
                        w_cw.psel = w_cb_taken ? PSEL_PCK : PSEL_PC4;
                        w_cw.sa   = 5'd31;
                        w_cw.sb   = r_ir[4:0];
                        w_cw.fsel = FSEL_ADD;
                        w_k       = sext19(r_ir[23:5]);
                    end
                    default: ;
                endcase
            end
            S_EXEC2: begin
                w_cw.psel = PSEL_PC4;
                w_cw.da   = r_ir[4:0];
                w_cw.sa   = r_ir[9:5];
                w_cw.fsel = FSEL_ADD;
                w_cw.regw = 1'b1;
                w_cw.dsel = DSEL_RAM;
                w_cw.bsel = 1'b1;
                w_k       = sext9(r_ir[20:12]);
            end
        endcase
        // Reset drops whatever this cycle would have written
        if (reset) begin
            w_cw = '0;
            w_k  = '0;
        end
    end

    assign bus.instr_ready = (r_state == S_FETCH);
    assign bus.controlWord = w_cw;
    assign bus.K           = w_k;
    assign bus.state       = r_state;
    assign bus.illegal     = r_illegal;
    assign bus.mem_timeout = r_timeout;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised bench for control_sequencer against a per-instruction
// reference model that expands each instruction into its cycle list.
module tb_control_sequencer;

    localparam int MAXW = 15;
    localparam int K_IAR = 0, K_LD = 1, K_ST = 2, K_B = 3;
    localparam int K_BC = 4, K_CB = 5, K_ILL = 6;
    localparam logic [4:0] ADD = 5'b01000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    control_sequencer_if bus();

    control_sequencer #(.MAX_WAIT(4'(MAXW))) u_dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int   n_run  = 0;
    int   n_fail = 0;
    logic exp_ill = 1'b0;
    logic exp_to  = 1'b0;

    typedef struct {
        logic [1:0]  st;
        logic [28:0] cw;
        logic [63:0] k;
        logic        vld;
        logic [31:0] ins;
        logic        mr;
        logic [3:0]  stat;
        logic        az;
        logic        si;
        logic        sto;
    } cyc_t;

    cyc_t q[$];

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [28:0] cw(
        logic [1:0] ps, logic [4:0] da, logic [4:0] sa, logic [4:0] sb,
        logic [4:0] fs, logic rw, logic mw, logic [1:0] ds, logic bs,
        logic sl);
        return {ps, da, sa, sb, fs, rw, mw, ds, bs, 1'b0, sl};
    endfunction

    function automatic bit cond_true(logic [3:0] c, logic [3:0] s);
        bit n, z, cf, v;
        {n, z, cf, v} = s;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cf;
            4'd3:    return !cf;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cf && !z;
            4'd9:    return !cf || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && n == v;
            4'd13:   return z || n != v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int kind_of(logic [31:0] i);
        if (i[28:22] == 7'b1000100) return K_IAR;
        if (i[31:21] == 11'b11111000010) return K_LD;
        if (i[31:21] == 11'b11111000000) return K_ST;
        if (i[31:26] == 6'b000101) return K_B;
        if (i[31:24] == 8'b01010100) return K_BC;
        if (i[31:25] == 7'b1011010) return K_CB;
        return K_ILL;
    endfunction

    function automatic cyc_t mk(logic [1:0] st, logic [28:0] c,
                                logic [63:0] k);
        cyc_t e;
        e.st   = st;
        e.cw   = c;
        e.k    = k;
        e.vld  = 1'($urandom);
        e.ins  = $urandom;
        e.mr   = 1'($urandom);
        e.stat = 4'($urandom);
        e.az   = 1'($urandom);
        e.si   = 1'b0;
        e.sto  = 1'b0;
        return e;
    endfunction

    // delay = number of mem_ready-low cycles in EXEC1 before completion
    task automatic model(logic [31:0] i, int delay, logic [3:0] s,
                         logic az);
        cyc_t e;
        logic [4:0] rt = i[4:0];
        logic [4:0] rn = i[9:5];
        longint k9  = longint'(i[20:12]);
        longint k19 = longint'(i[23:5]);
        longint k26 = longint'(i[25:0]);
        longint kz  = longint'(i[21:10]);
        int nw;
        bit t, to, mr;
        if (i[20]) k9 -= 512;
        if (i[23]) k19 -= 524288;
        if (i[25]) k26 -= 67108864;
        e = mk(2'd0, '0, '0);
        e.vld = 1'b1;
        e.ins = i;
        q.push_back(e);
        case (kind_of(i))
            K_IAR: q.push_back(mk(2'd1, cw(2'b01, rt, rn, 5'd0,
                       {4'b0100, i[30]}, 1, 0, 2'b01, 1, i[29]), 64'(kz)));
            K_B: q.push_back(mk(2'd1, cw(2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                       64'(k26)));
            K_BC: begin
                t = cond_true(i[3:0], s);
                e = mk(2'd1, cw(t ? 2'b10 : 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                       64'(k19));
                e.stat = s;
                q.push_back(e);
            end
            K_ILL: begin
                e = mk(2'd1, cw(2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0), '0);
                e.si = 1'b1;
                q.push_back(e);
            end
            K_CB: begin
                q.push_back(mk(2'd1, cw(0, 0, 31, rt, ADD, 0, 0, 0, 0, 0),
                               64'(k19)));
                t = az ^ i[24];
                e = mk(2'd2, cw(t ? 2'b10 : 2'b01, 0, 31, rt, ADD,
                                0, 0, 0, 0, 0), 64'(k19));
                e.az = az;
                q.push_back(e);
            end
            default: begin
                q.push_back(mk(2'd1, cw(0, 0, rn, 0, ADD, 0, 0, 0, 1, 0),
                               64'(k9)));
                nw = (delay >= MAXW) ? MAXW : delay + 1;
                for (int j = 0; j < nw; j++) begin
                    mr = (j == delay);
                    to = (delay >= MAXW) && (j == MAXW - 1);
                    if (kind_of(i) == K_ST)
                        e = mk(2'd2, cw((mr || to) ? 2'b01 : 2'b00, 0, rn, rt,
                                        ADD, 0, mr, 0, 1, 0), 64'(k9));
                    else
                        e = mk(2'd2, cw(to ? 2'b01 : 2'b00, 0, rn, 0, ADD,
                                        0, 0, 2'b10, 1, 0), 64'(k9));
                    e.mr  = mr;
                    e.sto = to;
                    q.push_back(e);
                end
                if (kind_of(i) == K_LD && delay < MAXW)
                    q.push_back(mk(2'd3, cw(2'b01, rt, rn, 0, ADD, 1, 0,
                                            2'b10, 1, 0), 64'(k9)));
            end
        endcase
    endtask

    task automatic run_q();
        cyc_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge clk);
            #1;
            bus.instr_valid = e.vld;
            bus.instruction = e.ins;
            bus.mem_ready   = e.mr;
            bus.status      = e.stat;
            bus.alu_zero    = e.az;
            @(negedge clk);
            chk("state", 64'(bus.state), 64'(e.st));
            chk("cw", 64'(bus.controlWord), 64'(e.cw));
            chk("K", bus.K, e.k);
            chk("ready", 64'(bus.instr_ready), 64'(e.st == 2'd0));
            chk("illegal", 64'(bus.illegal), 64'(exp_ill));
            chk("timeout", 64'(bus.mem_timeout), 64'(exp_to));
            if (e.si) exp_ill = 1'b1;
            if (e.sto) exp_to = 1'b1;
        end
    endtask

    task automatic reset_mid(logic [31:0] i);
        model(i, 20, 4'($urandom), 1'($urandom));
        while (q.size() > 3) void'(q.pop_back());
        run_q();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.mem_ready   = 1'b1;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        chk("rst_state", 64'(bus.state), 64'd2);
        chk("rst_cw", 64'(bus.controlWord), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.mem_ready   = 1'b0;
        bus.instr_valid = 1'b0;
        exp_ill = 1'b0;
        exp_to  = 1'b0;
        @(negedge clk);
        chk("post_state", 64'(bus.state), 64'd0);
        chk("post_cw", 64'(bus.controlWord), 64'd0);
        chk("post_K", bus.K, 64'd0);
        chk("post_ill", 64'(bus.illegal), 64'd0);
        chk("post_to", 64'(bus.mem_timeout), 64'd0);
    endtask

    function automatic logic [31:0] rand_ins(int kd);
        logic [31:0] i = $urandom;
        case (kd)
            K_IAR: i[28:22] = 7'b1000100;
            K_LD:  i[31:21] = 11'b11111000010;
            K_ST:  i[31:21] = 11'b11111000000;
            K_B:   i[31:26] = 6'b000101;
            K_BC:  i[31:24] = 8'b01010100;
            K_CB:  i[31:25] = 7'b1011010;
            default:
                while (kind_of(i) != K_ILL) i = $urandom;
        endcase
        return i;
    endfunction

    initial begin
        cyc_t e;
        int kd, dl;
        rst = 1'b1;
        bus.instruction = '0;
        bus.instr_valid = 1'b0;
        bus.status      = '0;
        bus.alu_zero    = 1'b0;
        bus.mem_ready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst0_state", 64'(bus.state), 64'd0);
        chk("rst0_cw", 64'(bus.controlWord), 64'd0);
        chk("rst0_K", bus.K, 64'd0);
        chk("rst0_ready", 64'(bus.instr_ready), 64'd1);
        chk("rst0_flags", 64'({bus.illegal, bus.mem_timeout}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        model(32'h91001441, 0, 4'd0, 1'b0);
        model(32'hF1000483, 0, 4'd0, 1'b0);
        model(32'hF85F80C5, 3, 4'd0, 1'b0);
        model(32'h54000080, 0, 4'b0000, 1'b0);
        model(32'h54000080, 0, 4'b0100, 1'b0);
        model(32'hB5000043, 0, 4'd0, 1'b0);
        model(32'hF8010041, 100, 4'd0, 1'b0);
        model(32'h00000000, 0, 4'd0, 1'b0);
        run_q();
        reset_mid(32'hF8010041);
        reset_mid(32'hF85F80C5);

        for (int n = 0; n < 200; n++) begin
            kd = $urandom_range(0, 6);
            dl = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 5);
            if ($urandom_range(0, 3) == 0) begin
                e = mk(2'd0, '0, '0);
                e.vld = 1'b0;
                q.push_back(e);
            end
            model(rand_ins(kd), dl, 4'($urandom), 1'($urandom));
            run_q();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
